// File: rtl/sd_pkg.sv
// Shared SD host definitions: command framing constants, CRC7 step,
// response types and the command transmitter state encoding.
package sd_pkg;

  localparam int unsigned CMD_FRAME_LEN = 48;
  localparam int unsigned CMD_HEAD_LEN  = 40;
  localparam logic [6:0]  CRC7_POLY     = 7'h09;

  typedef enum logic [1:0] {
    RSP_NONE  = 2'd0,
    RSP_SHORT = 2'd1,
    RSP_LONG  = 2'd2
  } rsp_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT_OUT,
    ST_GAP,
    ST_LISTEN
  } cmd_tx_state_e;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

  // The reserved encoding 3 behaves as "no response expected".
  function automatic rsp_type_e rsp_type_decode(input logic [1:0] raw);
    case (raw)
      2'd1:    return RSP_SHORT;
      2'd2:    return RSP_LONG;
      default: return RSP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/crc7_gen.sv
// Serial CRC7 accumulator; in shift_out mode it acts as a plain shift
// register so the finished CRC can be streamed MSB first from crc_o[6].
module crc7_gen
  import sd_pkg::*;
(
  input  logic       sd_clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       enable_i,
  input  logic       shift_out_i,
  input  logic       bit_i,
  output logic [6:0] crc_o
);

  always_ff @(posedge sd_clk_i or posedge rst_i) begin
    if (rst_i) begin
      crc_o <= '0;
    end else if (clear_i) begin
      crc_o <= '0;
    end else if (shift_out_i) begin
      crc_o <= {crc_o[5:0], 1'b0};
    end else if (enable_i) begin
      crc_o <= crc7_step(crc_o, bit_i);
    end
  end

endmodule

// File: rtl/cmd_write.sv
// SD host command transmitter: serialises a 48-bit command token on CMD
// and signals the downstream response receiver when to start listening.
module cmd_write
  import sd_pkg::*;
(
  input  logic        sd_clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [5:0]  cmd_index_i,
  input  logic [31:0] cmd_arg_i,
  input  logic [1:0]  rsp_type_i,
  output logic        cmd_o,
  output logic        cmd_en_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        start_listening_o,
  output logic        long_rsp_o
);

  localparam logic [5:0] HEAD_LAST     = 6'(CMD_HEAD_LEN - 1);
  localparam logic [5:0] CRC_LAST_LOAD = 6'(CMD_FRAME_LEN - 3);
  localparam logic [5:0] LAST_BIT      = 6'(CMD_FRAME_LEN - 1);

  cmd_tx_state_e state, state_nxt;
  rsp_type_e     rsp_type, rsp_type_nxt;
  logic [5:0]    cnt, cnt_nxt;
  logic [39:0]   head, head_nxt;
  logic          cmd_nxt, cmd_en_nxt, busy_nxt, done_nxt, listen_nxt, long_nxt;
  logic          crc_clear, crc_enable, crc_shift, crc_bit;
  logic [6:0]    crc;

  crc7_gen u_crc7 (
    .sd_clk_i    (sd_clk_i),
    .rst_i       (rst_i),
    .clear_i     (crc_clear),
    .enable_i    (crc_enable),
    .shift_out_i (crc_shift),
    .bit_i       (crc_bit),
    .crc_o       (crc)
  );

  // cmd_o is registered, so each edge loads the *next* bit: head[39] is the
  // bit on the line, head[38] the one about to go out and into the CRC.
  // The start bit is 0, so clearing the CRC on acceptance already accounts
  // for it and the CRC is complete when bit 40 has to be loaded.
  always_comb begin
    state_nxt    = state;
    rsp_type_nxt = rsp_type;
    cnt_nxt      = cnt;
    head_nxt     = head;
    cmd_nxt      = 1'b1;
    cmd_en_nxt   = 1'b0;
    busy_nxt     = 1'b0;
    done_nxt     = 1'b0;
    listen_nxt   = 1'b0;
    long_nxt     = long_rsp_o;
    crc_clear    = 1'b0;
    crc_enable   = 1'b0;
    crc_shift    = 1'b0;
    crc_bit      = head[38];

    case (state)
      ST_IDLE: begin
        if (start_i) begin
          head_nxt     = {2'b01, cmd_index_i, cmd_arg_i};
          rsp_type_nxt = rsp_type_decode(rsp_type_i);
          long_nxt     = (rsp_type_nxt == RSP_LONG);
          cnt_nxt      = '0;
          crc_clear    = 1'b1;
          cmd_nxt      = head_nxt[39];
          cmd_en_nxt   = 1'b1;
          busy_nxt     = 1'b1;
          state_nxt    = ST_SHIFT_OUT;
        end
      end

      ST_SHIFT_OUT: begin
        busy_nxt = 1'b1;
        if (cnt == LAST_BIT) begin
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
          state_nxt = ST_GAP;
        end else begin
          cnt_nxt    = cnt + 6'd1;
          cmd_en_nxt = 1'b1;
          head_nxt   = {head[38:0], 1'b0};
          if (cnt < HEAD_LAST) begin
            cmd_nxt    = head[38];
            crc_enable = 1'b1;
          end else if (cnt <= CRC_LAST_LOAD) begin
            cmd_nxt   = crc[6];
            crc_shift = 1'b1;
          end else begin
            cmd_nxt = 1'b1;
          end
        end
      end

      ST_GAP: begin
        busy_nxt   = 1'b1;
        listen_nxt = (rsp_type != RSP_NONE);
        state_nxt  = ST_LISTEN;
      end

      ST_LISTEN: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt    = ST_IDLE;
        cnt_nxt      = '0;
        rsp_type_nxt = RSP_NONE;
        long_nxt     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sd_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state             <= ST_IDLE;
      rsp_type          <= RSP_NONE;
      cnt               <= '0;
      head              <= '0;
      cmd_o             <= 1'b1;
      cmd_en_o          <= 1'b0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
      start_listening_o <= 1'b0;
      long_rsp_o        <= 1'b0;
    end else begin
      state             <= state_nxt;
      rsp_type          <= rsp_type_nxt;
      cnt               <= cnt_nxt;
      head              <= head_nxt;
      cmd_o             <= cmd_nxt;
      cmd_en_o          <= cmd_en_nxt;
      busy_o            <= busy_nxt;
      done_o            <= done_nxt;
      start_listening_o <= listen_nxt;
      long_rsp_o        <= long_nxt;
    end
  end

endmodule

// File: tb/tb_cmd_write.sv
// Self-checking bench for cmd_write: directed and randomized frames
// compared against a polynomial-division model of the command token.
module tb_cmd_write;

  logic        sd_clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [5:0]  cmd_index_i = '0;
  logic [31:0] cmd_arg_i = '0;
  logic [1:0]  rsp_type_i = '0;
  logic        cmd_o, cmd_en_o, busy_o, done_o, start_listening_o, long_rsp_o;

  int unsigned checks = 0;
  int unsigned failures = 0;

  cmd_write dut (
    .sd_clk_i          (sd_clk_i),
    .rst_i             (rst_i),
    .start_i           (start_i),
    .cmd_index_i       (cmd_index_i),
    .cmd_arg_i         (cmd_arg_i),
    .rsp_type_i        (rsp_type_i),
    .cmd_o             (cmd_o),
    .cmd_en_o          (cmd_en_o),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .start_listening_o (start_listening_o),
    .long_rsp_o        (long_rsp_o)
  );

  always #5 sd_clk_i = ~sd_clk_i;

  // CRC7 as the remainder of msg * x^7 divided by x^7 + x^3 + 1.
  function automatic logic [6:0] model_crc(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] model_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] msg;
    msg = {2'b01, idx, arg};
    return {msg, model_crc(msg), 1'b1};
  endfunction

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the request is sampled on the following posedge.
  task automatic start_frame(input logic [5:0] idx, input logic [31:0] arg,
                             input logic [1:0] typ, input bit hold);
    cmd_index_i = idx;
    cmd_arg_i   = arg;
    rsp_type_i  = typ;
    start_i     = 1'b1;
    @(posedge sd_clk_i);
    #1;
    if (!hold) start_i = 1'b0;
  endtask

  // Samples cycles T+1..T+51 on negedges; optionally aborts after cycle
  // abort_at, or pokes start/index/arg mid-frame.
  task automatic watch_frame(input string tag, input logic [47:0] frame,
                             input bit listen_exp, input bit long_exp,
                             input int unsigned abort_at, input bit disturb);
    for (int unsigned k = 1; k <= 51; k++) begin
      @(negedge sd_clk_i);
      check($sformatf("%s_cmd_c%0d", tag, k), 48'(cmd_o),
            (k <= 48) ? 48'(frame[48 - k]) : 48'd1);
      check($sformatf("%s_en_c%0d", tag, k), 48'(cmd_en_o), 48'(k <= 48));
      check($sformatf("%s_busy_c%0d", tag, k), 48'(busy_o), 48'(k <= 50));
      check($sformatf("%s_done_c%0d", tag, k), 48'(done_o), 48'(k == 49));
      check($sformatf("%s_listen_c%0d", tag, k), 48'(start_listening_o),
            48'((k == 50) && listen_exp));
      check($sformatf("%s_long_c%0d", tag, k), 48'(long_rsp_o), 48'(long_exp));
      if (k == abort_at) return;
      if (disturb) begin
        if (k == 10 || k == 49) begin
          start_i     = 1'b1;
          cmd_index_i = 6'(k);
          cmd_arg_i   = $urandom;
          rsp_type_i  = 2'd2;
        end else begin
          start_i = 1'b0;
        end
      end
    end
  endtask

  task automatic idle_cycles(input string tag, input int unsigned n, input bit long_exp);
    for (int unsigned k = 0; k < n; k++) begin
      @(negedge sd_clk_i);
      check($sformatf("%s_cmd_i%0d", tag, k), 48'(cmd_o), 48'd1);
      check($sformatf("%s_en_i%0d", tag, k), 48'(cmd_en_o), 48'd0);
      check($sformatf("%s_busy_i%0d", tag, k), 48'(busy_o | done_o | start_listening_o), 48'd0);
      check($sformatf("%s_long_i%0d", tag, k), 48'(long_rsp_o), 48'(long_exp));
    end
  endtask

  initial begin
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [1:0]  typ;

    // Reset state
    @(negedge sd_clk_i);
    check("rst_cmd", 48'(cmd_o), 48'd1);
    check("rst_en", 48'(cmd_en_o), 48'd0);
    check("rst_busy", 48'(busy_o), 48'd0);
    check("rst_done", 48'(done_o), 48'd0);
    check("rst_listen", 48'(start_listening_o), 48'd0);
    check("rst_long", 48'(long_rsp_o), 48'd0);
    @(negedge sd_clk_i);
    rst_i = 1'b0;
    idle_cycles("idle0", 3, 1'b0);

    // CMD0, NONE
    start_frame(6'd0, 32'h0, 2'd0, 1'b0);
    watch_frame("cmd0", 48'h40_00000000_95, 1'b0, 1'b0, 0, 1'b0);

    // CMD8, SHORT
    start_frame(6'd8, 32'h000001AA, 2'd1, 1'b0);
    watch_frame("cmd8", 48'h48_000001AA_87, 1'b1, 1'b0, 0, 1'b0);

    // CMD17 then CMD2 LONG back to back
    start_frame(6'd17, 32'h0, 2'd1, 1'b0);
    watch_frame("cmd17", 48'h51_00000000_55, 1'b1, 1'b0, 0, 1'b0);
    arg = $urandom;
    start_frame(6'd2, arg, 2'd2, 1'b0);
    watch_frame("cmd2", model_frame(6'd2, arg), 1'b1, 1'b1, 0, 1'b0);

    // Mid-frame start pulses and input changes are ignored
    start_frame(6'd8, 32'h000001AA, 2'd1, 1'b0);
    watch_frame("dist", 48'h48_000001AA_87, 1'b1, 1'b0, 0, 1'b1);
    start_i = 1'b0;
    idle_cycles("dist_after", 60, 1'b0);

    // Reset while bit 20 is on the line
    start_frame(6'd55, 32'hDEADBEEF, 2'd2, 1'b0);
    watch_frame("abort", model_frame(6'd55, 32'hDEADBEEF), 1'b1, 1'b1, 21, 1'b0);
    rst_i = 1'b1;
    #1;
    check("abort_cmd", 48'(cmd_o), 48'd1);
    check("abort_en", 48'(cmd_en_o), 48'd0);
    check("abort_busy", 48'(busy_o), 48'd0);
    check("abort_long", 48'(long_rsp_o), 48'd0);
    @(negedge sd_clk_i);
    @(negedge sd_clk_i);
    rst_i = 1'b0;
    idle_cycles("abort_after", 60, 1'b0);
    start_frame(6'd0, 32'h0, 2'd0, 1'b0);
    watch_frame("post_rst", 48'h40_00000000_95, 1'b0, 1'b0, 0, 1'b0);

    // start_i held high: a new frame at every IDLE visit
    arg = $urandom;
    start_frame(6'd41, arg, 2'd3, 1'b1);
    watch_frame("hold1", model_frame(6'd41, arg), 1'b0, 1'b0, 0, 1'b0);
    watch_frame("hold2", model_frame(6'd41, arg), 1'b0, 1'b0, 0, 1'b0);
    start_i = 1'b0;
    idle_cycles("hold_after", 5, 1'b0);

    // Randomized frames with random idle gaps
    for (int n = 0; n < 8; n++) begin
      idx = 6'($urandom);
      arg = $urandom;
      typ = 2'($urandom_range(0, 3));
      start_frame(idx, arg, typ, 1'b0);
      watch_frame($sformatf("rnd%0d", n), model_frame(idx, arg),
                  (typ == 2'd1) || (typ == 2'd2), typ == 2'd2, 0, 1'b0);
      idle_cycles($sformatf("rnd%0d_gap", n), $urandom_range(0, 4), typ == 2'd2);
    end

    // Long idle stretch
    rst_i = 1'b1;
    @(negedge sd_clk_i);
    rst_i = 1'b0;
    idle_cycles("idle200", 200, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmd_write.md
# cmd_write

Host-side SD command transmitter. It serialises one 48-bit command token (start bit, transmission bit, 6-bit index, 32-bit argument, CRC7, end bit) onto the CMD line, MSB first, and computes the CRC7 on the fly. It sits directly upstream of the response receiver. It hands that receiver the response type and a one-cycle `start_listening_o` pulse on the 2nd cycle after the end bit.

## Interface
- No parameters; frame length 48 and CRC7 polynomial come from `sd_pkg`.
- `sd_clk_i` in 1: SD card clock; all logic on rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `start_i` in 1: request to send; sampled only in IDLE.
- `cmd_index_i` in 6: command index; captured when `start_i` is accepted.
- `cmd_arg_i` in 32: command argument; captured with the index.
- `rsp_type_i` in 2: `sd_pkg::rsp_type_e`, one of NONE (0), SHORT (1), LONG (2); captured with the index. Value 3 is treated as NONE.
- `cmd_o` out 1: serial CMD data, registered; idles high.
- `cmd_en_o` out 1: CMD output-driver enable, registered; high only while frame bits are on `cmd_o`.
- `busy_o` out 1: high from the first frame bit until the return to IDLE.
- `done_o` out 1: one-cycle pulse on the cycle after the end bit.
- `start_listening_o` out 1: one-cycle pulse on the 2nd cycle after the end bit; only when the latched type is not NONE.
- `long_rsp_o` out 1: latched type == LONG; held until the next accepted start.

## Operation
- States: IDLE, SHIFT_OUT, GAP, LISTEN.
- IDLE:
  - `start_i` = 1: latch the 40-bit head {0, 1, index, arg}, latch the response type, clear the bit counter and CRC, go to SHIFT_OUT.
- SHIFT_OUT: one bit per cycle; 6-bit counter runs 0..47.
  - Bits 0..39: head bits, MSB first. Each bit is fed to the CRC.
  - Bits 40..46: CRC7, MSB first. The CRC register shifts out and takes no new input.
  - Bit 47: end bit, 1. At count 47 go to GAP.
- GAP: `cmd_en_o` = 0, `cmd_o` = 1, `done_o` = 1; go to LISTEN.
- LISTEN:
  - `start_listening_o` = 1 if the latched type is not NONE.
  - Go to IDLE. The timing is identical for every response type.
- CRC7:
  - Polynomial x^7 + x^3 + 1, initial value 0.
  - Per bit: fb = b ^ crc[6]; crc = {crc[5:0], 0} ^ (fb ? 7'h09 : 0).
- `start_i` outside IDLE is ignored and not queued. Inputs changing after acceptance have no effect.
- Counter never wraps: leaving SHIFT_OUT at 47 is mandatory. Unreachable states go to IDLE with outputs at reset values.

## Timing
- Reset values: `cmd_o` = 1; `cmd_en_o`, `busy_o`, `done_o`, `start_listening_o`, `long_rsp_o` = 0; state IDLE; counter 0; CRC 0.
- `start_i` high in IDLE at edge T:
  - Bit 0 (start bit, 0) on `cmd_o` in cycle T+1; bit k in cycle T+1+k.
  - End bit in T+48.
  - `done_o` in T+49.
  - `start_listening_o` in T+50.
  - IDLE in T+51, where a new `start_i` can be accepted. Back-to-back period is 51 cycles.
- `cmd_en_o` high in T+1..T+48 exactly. `busy_o` high in T+1..T+50.
- Reset mid-frame: outputs return to reset values asynchronously. No `done_o` or `start_listening_o` pulse is emitted for the aborted frame.
- `start_i` held high continuously: a frame starts at every IDLE visit, every 51 cycles.

## Structure
- `sd_pkg`:
  - `rsp_type_e`.
  - `CMD_FRAME_LEN` = 48, `CMD_HEAD_LEN` = 40.
  - `CRC7_POLY` = 7'h09.
  - `cmd_tx_state_e`.
- Sub-module `crc7_gen`:
  - Serial CRC7 with ports clear, enable, shift_out, bit input, crc output. It also serves the shift-out of bits 40..46.
- Top level holds the FSM, the 6-bit counter and the 40-bit head shift register.

## Test plan
- CMD0, arg 0x00000000, NONE: `cmd_o` bits = 0x40_00000000_95 (CRC 0x4A). `done_o` at T+49. No `start_listening_o`. `long_rsp_o` = 0.
- CMD8, arg 0x000001AA, SHORT: bits = 0x48_000001AA_87. `start_listening_o` exactly at T+50. `long_rsp_o` = 0.
- CMD17, arg 0x00000000, SHORT, then CMD2 (LONG) started at T+51: first frame = 0x51_00000000_55. Second frame starts at T+52 with `long_rsp_o` = 1 and a correct CRC.
- `start_i` pulsed at T+10 and T+49 during a frame, and index/arg changed mid-frame: frame unchanged, no second frame.
- `rst_i` asserted at bit 20: immediately `cmd_o` = 1 and `cmd_en_o` = 0. No `done_o`/`start_listening_o` after release. The next start produces a correct frame.
- Idle check: with no `start_i`, `cmd_o` stays 1 and `cmd_en_o` stays 0 for 200 cycles.
